memory_arbiter: RTL

//  Responder side of cache_control_if: services icache fetch and dcache read/write requests

---
 rtl/cache_pkg.sv | 29 ++
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/memarb_watchdog.sv | 46 ++++
 rtl/memory_arbiter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cache_pkg
//  Purpose  : Arbiter state encoding and grant bookkeeping types.
//  Revision : 1.0  initial release
// ============================================================================
package cache_pkg;

    localparam int unsigned C_WD_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFETCH = 2'd1,
        DREAD  = 2'd2,
        DWRITE = 2'd3
    } memarb_state_t;

    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } grant_t;

    // True while the arbiter owns the RAM on behalf of a requester
    function automatic logic is_granted(input memarb_state_t s);
        return (s != IDLE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_types_pkg
//  Purpose  : Shared CPU-wide types: machine word and RAM handshake state.
//  Revision : 1.0  initial release
// ============================================================================
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Status reported by the RAM model every cycle
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage
`default_nettype wire

// File: rtl/memarb_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : memarb_watchdog
//  Purpose  : Counts consecutive granted cycles and raises a one-cycle
//             timeout at TIMEOUT-1 plus a sticky error flag. The module only
//             exists in builds with MEMARB_WATCHDOG_EN defined.
//  Revision : 1.0  initial release
// ============================================================================
`ifdef MEMARB_WATCHDOG_EN
module memarb_watchdog
    import cache_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic CLK,
    input  logic nRST,
    input  logic i_granted,
    output logic o_timeout,
    output logic o_memerr
);

    localparam logic [C_WD_WIDTH-1:0] C_LIMIT = C_WD_WIDTH'(TIMEOUT - 1);

    logic [C_WD_WIDTH-1:0] r_count;
    logic                  r_err;

    // Cycle counter: held at zero while idle, counts while a grant is open
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)           r_count <= '0;
        else if (!i_granted) r_count <= '0;
        else                 r_count <= r_count + 1'b1;
    end

    // Sticky error, cleared only by reset
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)          r_err <= 1'b0;
        else if (o_timeout) r_err <= 1'b1;
    end

    assign o_timeout = i_granted && (r_count == C_LIMIT);
    // Flag is visible in the expiry cycle itself, then held by r_err
    assign o_memerr  = r_err | o_timeout;

endmodule
`endif
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : memory_arbiter
//  Purpose  : Responder side of the cache control interface. Grants the
//             single-ported RAM to one of icache fetch / dcache read / dcache
//             write at a time, alternating between instruction and data when
//             both contend. Optional watchdog: MEMARB_WATCHDOG_EN.
//  Revision : 1.0  initial release
// ============================================================================
module memory_arbiter
    import cpu_types_pkg::*;
    import cache_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic      CLK,
    input  logic      nRST,
    // cache side
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      iwait,
    output logic      dwait,
    output word_t     iload,
    output word_t     dload,
    // RAM side
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    // status
    output logic      memerr
);

    memarb_state_t r_state;
    grant_t        r_last_grant;
    logic          w_timeout;
    logic          w_access;
    logic          w_done;

    assign w_access = (ramstate == ACCESS);
    // A watchdog expiry pre-empts completion so no wait pulse is issued
    assign w_done   = w_access && !w_timeout;

`ifdef MEMARB_WATCHDOG_EN
    logic w_granted;
    assign w_granted = is_granted(r_state);

    memarb_watchdog #(
        .TIMEOUT   (TIMEOUT)
    ) u_watchdog (
        .CLK       (CLK),
        .nRST      (nRST),
        .i_granted (w_granted),
        .o_timeout (w_timeout),
        .o_memerr  (memerr)
    );
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^(32'(TIMEOUT));
    assign w_timeout        = 1'b0;
    assign memerr           = 1'b0;
`endif

    // Grant FSM: pick a requester in IDLE, release on completion/withdraw/timeout
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= IDLE;
            r_last_grant <= DATA;
        end else begin
            case (r_state)
                IDLE: begin
                    // Data served last and instruction waiting: instruction goes first
                    if ((dWEN || dREN) && iREN && (r_last_grant == DATA)) begin
                        r_state      <= IFETCH;
                        r_last_grant <= INSTR;
                    end else if (dWEN) begin
                        r_state      <= DWRITE;
                        r_last_grant <= DATA;
                    end else if (dREN) begin
                        r_state      <= DREAD;
                        r_last_grant <= DATA;
                    end else if (iREN) begin
                        r_state      <= IFETCH;
                        r_last_grant <= INSTR;
                    end
                end
                IFETCH: if (!iREN || w_timeout || w_access) r_state <= IDLE;
                DREAD:  if (!dREN || w_timeout || w_access) r_state <= IDLE;
                DWRITE: if (!dWEN || w_timeout || w_access) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Output decode: strobes only while the granted request is still held
    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (r_state)
            IFETCH: if (iREN) begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (w_done) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            DREAD: if (dREN) begin
                ramREN  = 1'b1;
                ramaddr = daddr;
                if (w_done) begin
                    dwait = 1'b0;
                    dload = ramload;
                end
            end
            DWRITE: if (dWEN) begin
                ramWEN   = 1'b1;
                ramaddr  = daddr;
                ramstore = dstore;
                if (w_done) dwait = 1'b0;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
